// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device command transmitter driving ps2_clk/ps2_data through pull-low enables.
// Optional build macro PS2_TX_RETRY_EN re-sends a NACKed or timed-out byte up to MAX_RETRIES times.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // The REQ cycle is the last of the INHIBIT_CYCLES cycles with ps2_clk pulled low.
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef PS2_TX_RETRY_EN
  localparam int RETRY_LIMIT = MAX_RETRIES;
`else
  // Retries compiled out: a limit of zero makes every failure final.
  localparam int RETRY_LIMIT = MAX_RETRIES - MAX_RETRIES;
`endif
  localparam int RW = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRY_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    BITS,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           state_reg;
  logic [1:0]       clk_sync_reg;
  logic [1:0]       data_sync_reg;
  logic             clk_prev_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       bit_cnt_reg;
  logic [9:0]       frame_reg;
  logic [9:0]       shift_reg;
  logic             nack_reg;
  logic [RW-1:0]    retry_reg;
  logic             clk_oe_reg;
  logic             data_oe_reg;
  logic             done_reg;
  logic             err_reg;

  logic clk_s;
  logic data_s;
  logic fall;
  logic in_xfer;
  logic line_idle;
  logic timeout_hit;
  logic fail_now;
  logic can_retry;
  logic retry_start;

  assign clk_s       = clk_sync_reg[1];
  assign data_s      = data_sync_reg[1];
  assign fall        = clk_prev_reg & ~clk_s;
  assign in_xfer     = (state_reg == BITS) || (state_reg == ACK) || (state_reg == WAIT_IDLE);
  assign line_idle   = clk_s & data_s;
  assign timeout_hit = in_xfer && (cnt_reg == TIMEOUT_LAST);
  assign fail_now    = timeout_hit || ((state_reg == WAIT_IDLE) && line_idle && nack_reg);
  assign can_retry   = (RETRY_LIMIT != 0) && (retry_reg != RETRY_MAX);
  assign retry_start = fail_now && can_retry;

  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;
  assign tx_ready    = (state_reg == IDLE);
  assign busy        = ~tx_ready;
  assign tx_done     = done_reg;
  assign tx_err      = err_reg;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      clk_prev_reg  <= 1'b1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk_in};
      data_sync_reg <= {data_sync_reg[0], ps2_data_in};
      clk_prev_reg  <= clk_sync_reg[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      frame_reg   <= '1;
      shift_reg   <= '1;
      nack_reg    <= 1'b0;
      retry_reg   <= '0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tx_valid) begin
            // Frame as shifted out LSB first: data, odd parity, stop.
            frame_reg  <= {1'b1, ~^tx_data, tx_data};
            cnt_reg    <= '0;
            retry_reg  <= '0;
            clk_oe_reg <= 1'b1;
            state_reg  <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt_reg == INHIBIT_LAST) begin
            data_oe_reg <= 1'b1;
            state_reg   <= REQ;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        REQ: begin
          clk_oe_reg  <= 1'b0;
          cnt_reg     <= '0;
          bit_cnt_reg <= '0;
          shift_reg   <= frame_reg;
          state_reg   <= BITS;
        end
        BITS, ACK, WAIT_IDLE: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (retry_start) begin
            retry_reg   <= retry_reg + RW'(1);
            clk_oe_reg  <= 1'b1;
            data_oe_reg <= 1'b0;
            cnt_reg     <= '0;
            state_reg   <= INHIBIT;
          end else if (timeout_hit) begin
            clk_oe_reg  <= 1'b0;
            data_oe_reg <= 1'b0;
            done_reg    <= 1'b1;
            err_reg     <= 1'b1;
            state_reg   <= IDLE;
          end else if (state_reg == BITS) begin
            if (fall) begin
              data_oe_reg <= ~shift_reg[0];
              shift_reg   <= {1'b1, shift_reg[9:1]};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd9) begin
                state_reg <= ACK;
              end
            end
          end else if (state_reg == ACK) begin
            if (fall) begin
              nack_reg  <= data_s;
              state_reg <= WAIT_IDLE;
            end
          end else if (line_idle) begin
            done_reg  <= 1'b1;
            err_reg   <= nack_reg;
            state_reg <= IDLE;
          end
        end
        default: begin
          clk_oe_reg  <= 1'b0;
          data_oe_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: scoreboard bench for ps2_tx with a behavioural PS/2 device clocking at a 500-cycle period.
// Builds with or without PS2_TX_RETRY_EN; the expected attempt count follows the macro.
module tb_ps2_tx;

  localparam int INH  = 100;
  localparam int TMO  = 20000;
  localparam int HALF = 250;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  // Hand-computed line frames {stop, parity, data[7:0], start}
  localparam logic [10:0] FRAME_ED = 11'b1_1_1110_1101_0;
  localparam logic [10:0] FRAME_FF = 11'b1_1_1111_1111_0;
  localparam logic [10:0] FRAME_00 = 11'b1_1_0000_0000_0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRIES   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
    bit          chk_frame;
    int          err;
    int          inh;
    int          inh_base;
    int          gap;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  int          cycle = 0;
  int          oe_run = 0;
  int          last_inh_len = 0;
  int          inh_pulses = 0;
  int          last_rel = 0;
  int          done_count = 0;
  logic [10:0] obs_frame = '0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: tracks clock-inhibit pulses and scores every tx_done against the queue.
  always @(negedge clk) begin
    cycle++;
    if (reset) begin
      oe_run = 0;
    end else if (ps2_clk_oe === 1'b1) begin
      oe_run++;
    end else if (oe_run != 0) begin
      last_inh_len = oe_run;
      inh_pulses++;
      last_rel = cycle;
      oe_run = 0;
    end
    if (tx_done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_tx_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("txn 0x%02h: tx_err=%0d frame=0x%03h inhibits=%0d inhibit_len=%0d gap=%0d",
                 mon_e.data, tx_err, obs_frame, inh_pulses - mon_e.inh_base, last_inh_len,
                 cycle - last_rel);
        check($sformatf("tx_err_%02h", mon_e.data), int'(tx_err), mon_e.err);
        if (mon_e.chk_frame)
          check($sformatf("frame_%02h", mon_e.data), int'(obs_frame), int'(mon_e.frame));
        check($sformatf("inhibit_count_%02h", mon_e.data), inh_pulses - mon_e.inh_base, mon_e.inh);
        check($sformatf("inhibit_len_%02h", mon_e.data), last_inh_len, INH);
        if (mon_e.gap > 0)
          check($sformatf("timeout_gap_%02h", mon_e.data), cycle - last_rel, mon_e.gap);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [10:0] frame, input bit chk_frame,
                      input int err, input int inh, input int gap, input bit expect_done);
    exp_t e;
    int   n;
    if (expect_done) begin
      e.data      = d;
      e.frame     = frame;
      e.chk_frame = chk_frame;
      e.err       = err;
      e.inh       = inh;
      e.inh_base  = inh_pulses;
      e.gap       = gap;
      exp_q.push_back(e);
    end
    n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", int'(tx_ready), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // One device-side attempt: clocks 11 falling edges, sampling data on each rising edge.
  task automatic dev_attempt(input bit nack, input int abort_after, input bit inject);
    int n;
    n = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1 && busy === 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      check("request_to_send_seen", 0, 1);
      return;
    end
    obs_frame    = '0;
    obs_frame[0] = ps2_data_in;
    repeat (HALF) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      for (int k = 0; k < HALF; k++) begin
        tx_valid = inject && (i == 3) && (k == 10);
        if (tx_valid) tx_data = 8'h55;
        @(negedge clk);
      end
      tx_valid     = 1'b0;
      dev_clk_low  = 1'b0;
      obs_frame[i] = ps2_data_in;
      if (i == abort_after) return;
      repeat (HALF) @(negedge clk);
    end
    dev_data_low = !nack;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (50) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input string name, input int start, input int bound, input int exp_err);
    int n;
    n = 0;
    while (done_count == start && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_count"}, done_count - start, 1);
    @(negedge clk);
    check({name, "_ready_after"}, int'(tx_ready), 1);
    check({name, "_clk_oe_after"}, int'(ps2_clk_oe), 0);
    check({name, "_data_oe_after"}, int'(ps2_data_oe), 0);
    check({name, "_err_hold"}, int'(tx_err), exp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_clk_oe", int'(ps2_clk_oe), 0);
    check("rst_data_oe", int'(ps2_data_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tx_done", int'(tx_done), 0);
    check("rst_tx_err", int'(tx_err), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx_ready", int'(tx_ready), 1);

    // 0xED acknowledged
    start = done_count;
    send(8'hED, FRAME_ED, 1'b1, 0, 1, 0, 1'b1);
    dev_attempt(1'b0, 0, 1'b0);
    wait_done("ed_ack", start, 3000, 0);

    // 0xFF NACKed on every attempt
    start = done_count;
    send(8'hFF, FRAME_FF, 1'b1, 1, ATTEMPTS, 0, 1'b1);
    for (int a = 0; a < ATTEMPTS; a++) dev_attempt(1'b1, 0, 1'b0);
    wait_done("ff_nack", start, 3000, 1);

    // 0xF4 with a silent device: timeout
    start = done_count;
    send(8'hF4, 11'h0, 1'b0, 1, ATTEMPTS, TMO, 1'b1);
    wait_done("f4_timeout", start, ATTEMPTS * (TMO + 500) + 1000, 1);

    // Reset after the 4th falling edge, then a clean 0x00
    start = done_count;
    send(8'h5A, 11'h0, 1'b0, 0, 0, 0, 1'b0);
    dev_attempt(1'b0, 4, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_clk_oe", int'(ps2_clk_oe), 0);
    check("abort_data_oe", int'(ps2_data_oe), 0);
    check("abort_tx_ready", int'(tx_ready), 1);
    check("abort_busy", int'(busy), 0);
    repeat (1000) @(negedge clk);
    check("abort_no_done", done_count - start, 0);
    start = done_count;
    send(8'h00, FRAME_00, 1'b1, 0, 1, 0, 1'b1);
    dev_attempt(1'b0, 0, 1'b0);
    wait_done("zero_after_abort", start, 3000, 0);

    // 0x55 offered while busy with 0xED must be dropped
    start = done_count;
    send(8'hED, FRAME_ED, 1'b1, 0, 1, 0, 1'b1);
    dev_attempt(1'b0, 0, 1'b1);
    wait_done("busy_ignore", start, 3000, 0);
    repeat (300) @(negedge clk);
    check("busy_ignore_idle_ready", int'(tx_ready), 1);
    check("busy_ignore_no_inhibit", int'(ps2_clk_oe), 0);
    check("busy_ignore_single_done", done_count - start, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
